// File: rtl/paillier_pkg.sv
// Shared types and default word geometry for the Paillier datapath blocks
// (Montgomery reduction and the multiplier that feeds it).
package paillier_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_S = 2;

    typedef enum logic [2:0] {
        IDLE,
        CALC_U,
        MAC,
        CARRY,
        FINAL,
        OUTPUT
    } redc_state_t;

endpackage

// File: rtl/mont_word_mac.sv
// Single-word multiply-accumulate: {hi,lo} = a + x*y + c; the sum always fits in 2W bits.
module mont_word_mac
    import paillier_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] c,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    logic [2*W-1:0] prod;

    assign prod     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    assign {hi, lo} = prod + {{W{1'b0}}, a} + {{W{1'b0}}, c};

endmodule

// File: rtl/montgomery_redc.sv
// Word-serial Montgomery reduction: result = T * R^-1 mod m, R = 2^(S*W).
// Optional macro MONTGOMERY_REDC_ODD_CHECK_EN flags an even modulus through err.
module montgomery_redc
    import paillier_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int S = DEF_S
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*S*W-1:0] t_in,
    input  logic [S*W-1:0]   m_in,
    input  logic [W-1:0]     m_prime,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [S*W-1:0]   result,
    output logic             err
);

    localparam int N  = S * W;
    localparam int IW = $clog2(2 * S) + 1;

    redc_state_t     state;
    logic [2*N-1:0]  t_reg;
    logic [N-1:0]    m_reg;
    logic [W-1:0]    mp_reg;
    logic [W-1:0]    u;
    logic [W-1:0]    carry;
    logic            c_top;
    logic [IW-1:0]   i;
    logic [IW-1:0]   j;
    logic [IW-1:0]   idx_ij;
    logic [IW-1:0]   idx_is;
    logic [W-1:0]    mac_a, mac_x, mac_y, mac_c, mac_hi, mac_lo;

    // V < 2m is guaranteed by T < m*R, so one borrow-chain subtraction fully reduces.
    function automatic logic [N-1:0] final_reduce(input logic [N:0] v, input logic [N-1:0] m);
        logic [N+1:0] diff;
        diff = {1'b0, v} - {2'b00, m};
        return diff[N+1] ? v[N-1:0] : diff[N-1:0];
    endfunction

    assign idx_ij = i + j;
    assign idx_is = i + IW'(S);

    // One MAC serves all three arithmetic states: u = T[i]*m' (low word),
    // the row accumulate, and the carry fold-in (x*1 + c_top).
    always_comb begin
        mac_a = '0;
        mac_x = '0;
        mac_y = '0;
        mac_c = '0;
        unique case (state)
            CALC_U: begin
                mac_x = t_reg[int'(i)*W +: W];
                mac_y = mp_reg;
            end
            MAC: begin
                mac_a = t_reg[int'(idx_ij)*W +: W];
                mac_x = u;
                mac_y = m_reg[int'(j)*W +: W];
                mac_c = carry;
            end
            CARRY: begin
                mac_a = t_reg[int'(idx_is)*W +: W];
                mac_x = carry;
                mac_y = W'(1);
                mac_c = {{(W-1){1'b0}}, c_top};
            end
            default: ;
        endcase
    end

    mont_word_mac #(.W(W)) u_mac (
        .a  (mac_a),
        .x  (mac_x),
        .y  (mac_y),
        .c  (mac_c),
        .hi (mac_hi),
        .lo (mac_lo)
    );

`ifdef MONTGOMERY_REDC_ODD_CHECK_EN
    logic odd_fail;
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            t_reg     <= '0;
            m_reg     <= '0;
            mp_reg    <= '0;
            u         <= '0;
            carry     <= '0;
            c_top     <= 1'b0;
            i         <= '0;
            j         <= '0;
`ifdef MONTGOMERY_REDC_ODD_CHECK_EN
            odd_fail  <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        t_reg    <= t_in;
                        m_reg    <= m_in;
                        mp_reg   <= m_prime;
                        i        <= '0;
                        c_top    <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= CALC_U;
`ifdef MONTGOMERY_REDC_ODD_CHECK_EN
                        odd_fail <= ~m_in[0];
                        err_q    <= 1'b0;
`endif
                    end
                end
                CALC_U: begin
`ifdef MONTGOMERY_REDC_ODD_CHECK_EN
                    if (odd_fail) begin
                        result    <= '0;
                        err_q     <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end else
`endif
                    begin
                        u     <= mac_lo;
                        j     <= '0;
                        carry <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    t_reg[int'(idx_ij)*W +: W] <= mac_lo;
                    carry <= mac_hi;
                    if (j == IW'(S - 1)) state <= CARRY;
                    else                 j     <= j + 1'b1;
                end
                CARRY: begin
                    t_reg[int'(idx_is)*W +: W] <= mac_lo;
                    c_top <= mac_hi[0];
                    if (i == IW'(S - 1)) begin
                        state <= FINAL;
                    end else begin
                        i     <= i + 1'b1;
                        state <= CALC_U;
                    end
                end
                FINAL: begin
                    result    <= final_reduce({c_top, t_reg[2*N-1:N]}, m_reg);
                    out_valid <= 1'b1;
                    state     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/montgomery_redc.md
MONTGOMERY_REDC -- requirements
Module: montgomery_redc

Interface
REQ-001 Parameter W, default 8, word width in bits.
REQ-002 Parameter S, default 2, modulus length in words (S >= 2).
REQ-003 clk  input  1  clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand set valid.
REQ-006 in_ready  output  1  block idle, can accept operands.
REQ-007 t_in  input  2*S*W  double-width value T in Montgomery form; word k = bits [k*W +: W]; caller guarantees T < m*R, R = 2^(S*W).
REQ-008 m_in  input  S*W  odd modulus m.
REQ-009 m_prime  input  W  -m^-1 mod 2^W.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  S*W  T*R^-1 mod m, fully reduced into [0, m).
REQ-013 err  output  1  even-modulus flag; constant 0 when the macro is off.

Function
REQ-014 Acceptance happens on a rising edge with in_valid && in_ready; t_in, m_in and m_prime SHALL be registered then and ignored afterwards.
REQ-015 FSM states: IDLE, CALC_U, MAC, CARRY, FINAL, OUTPUT.
REQ-016 IDLE: in_ready=1; on acceptance -> CALC_U, i=0, top-carry c_top=0.
REQ-017 CALC_U (1 cycle): u = (T[i]*m_prime) mod 2^W; j=0, carry=0 -> MAC.
REQ-018 MAC (S cycles, j=0..S-1): {carry,T[i+j]} = T[i+j] + u*M[j] + carry; carry is W bits wide; after j=S-1 -> CARRY.
REQ-019 CARRY (1 cycle): {c_top,T[i+S]} = T[i+S] + carry + c_top; if i==S-1 -> FINAL, else i++ -> CALC_U.
REQ-020 FINAL (1 cycle): V = {c_top, T[2S-1:S]}; result = (V >= m) ? V-m : V[S*W-1:0], using a borrow-chain compare where equality subtracts -> OUTPUT.
REQ-021 OUTPUT: out_valid=1 with result held stable until out_valid && out_ready -> IDLE; in_ready stays 0 throughout.
REQ-022 Latency: acceptance edge = edge 0; out_valid SHALL rise after edge S*(S+2)+1 (edge 9 for S=2), independent of data.
REQ-023 Back-to-back operation: the earliest next acceptance is the edge after the output handshake; there is no overlap.
REQ-024 in_valid during a busy state SHALL be ignored, with no effect on state or data.
REQ-025 All arithmetic is unsigned; word products are 2W bits; no intermediate truncation other than the defined mod 2^W for u.

Reset
REQ-026 rst_n low: state=IDLE, in_ready=1 after release, out_valid=0, result=0, err=0, i=j=0, carry=c_top=0, operand registers 0.
REQ-027 Reset mid-operation SHALL abort immediately; no out_valid is produced for the aborted operand.

Configuration
REQ-028 Macro MONTGOMERY_REDC_ODD_CHECK_EN defined: at acceptance, if m_in bit 0 is 0, the block goes directly to OUTPUT on the next edge with result=0, err=1; err is cleared on the next acceptance.
REQ-029 Macro not defined: no parity check; err is tied 0; an even modulus gives an undefined result with normal latency.

Structure
REQ-030 Shared package paillier_pkg SHALL hold the state enum redc_state_t and the default W and S constants, shared with the multiplier.
REQ-031 One sub-module, mont_word_mac, is natural: combinational {hi,lo} = a + x*y + c on W-bit words, reused by MAC and the multiplier.

Verification (W=8, S=2, m=0x00F1, m_prime=0xEF, R=0x10000)
REQ-032 t_in=0x0001_0000 -> result=0x0001, out_valid after edge 9, err=0.
REQ-033 t_in=0x0005_0000 -> result=0x0005; t_in=0 -> result=0x0000.
REQ-034 t_in=0x00F0_FFFF (m*R-1) -> result=0x00E2; FINAL subtraction path taken.
REQ-035 out_ready held low 3 cycles after out_valid -> result and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE on the next edge.
REQ-036 rst_n pulsed at edge 4 of an operation -> out_valid never asserts; the next operand t_in=0x0001_0000 gives result 0x0001.
REQ-037 With MONTGOMERY_REDC_ODD_CHECK_EN, m_in=0x00F0 -> out_valid on edge 1, err=1, result=0; next valid operand clears err.
